// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key-search datapath.
// Holds the plaintext reader state encoding and the printable-range helper.
package arc4_pkg;

  localparam int MEM_AW = 8;
  localparam int MEM_DW = 8;

  localparam logic [MEM_DW-1:0] PRINT_LO = 8'h20;
  localparam logic [MEM_DW-1:0] PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    PR_IDLE,
    PR_LEN_REQ,
    PR_LEN_DATA,
    PR_CH_REQ,
    PR_CH_DATA,
    PR_EMIT
  } pr_state_t;

  function automatic logic is_printable(
    input logic [MEM_DW-1:0] b,
    input logic [MEM_DW-1:0] lo,
    input logic [MEM_DW-1:0] hi
  );
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/pt_reader.sv
// Reads the length-prefixed plaintext, streams printable bytes out and
// reports pass/fail plus the first bad index to the key-search controller.
module pt_reader
  import arc4_pkg::*;
#(
  parameter logic [7:0] LO_CHAR = PRINT_LO,
  parameter logic [7:0] HI_CHAR = PRINT_HI
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       result_vld,
  output logic       pt_ok,
  output logic [7:0] bad_idx
);

  pr_state_t  state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] addr_d;
  logic [7:0] char_d;
  logic       valid_d;
  logic       rdy_d;
  logic       rvld_d;
  logic       ok_d;
  logic [7:0] bad_d;

  // Register every output and the FSM state; reset clears all of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PR_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      pt_addr    <= '0;
      out_char   <= '0;
      out_valid  <= 1'b0;
      rdy        <= 1'b1;
      result_vld <= 1'b0;
      pt_ok      <= 1'b0;
      bad_idx    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      pt_addr    <= addr_d;
      out_char   <= char_d;
      out_valid  <= valid_d;
      rdy        <= rdy_d;
      result_vld <= rvld_d;
      pt_ok      <= ok_d;
      bad_idx    <= bad_d;
    end
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = pt_addr;
    char_d  = out_char;
    valid_d = out_valid;
    rdy_d   = rdy;
    rvld_d  = result_vld;
    ok_d    = pt_ok;
    bad_d   = bad_idx;
    unique case (state_q)
      PR_IDLE: begin
        if (en) begin
          rdy_d   = 1'b0;
          rvld_d  = 1'b0;
          addr_d  = '0;
          state_d = PR_LEN_REQ;
        end
      end
      PR_LEN_REQ: begin
        state_d = PR_LEN_DATA;
      end
      PR_LEN_DATA: begin
        len_d = pt_rddata;
        idx_d = 8'd1;
        if (pt_rddata == 8'd0) begin
          ok_d    = 1'b1;
          bad_d   = '0;
          rvld_d  = 1'b1;
          rdy_d   = 1'b1;
          state_d = PR_IDLE;
        end else begin
          addr_d  = 8'd1;
          state_d = PR_CH_REQ;
        end
      end
      PR_CH_REQ: begin
        state_d = PR_CH_DATA;
      end
      PR_CH_DATA: begin
        if (is_printable(pt_rddata, LO_CHAR, HI_CHAR)) begin
          char_d  = pt_rddata;
          valid_d = 1'b1;
          state_d = PR_EMIT;
        end else begin
          ok_d    = 1'b0;
          bad_d   = idx_q;
          rvld_d  = 1'b1;
          rdy_d   = 1'b1;
          state_d = PR_IDLE;
        end
      end
      PR_EMIT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (idx_q == len_q) begin
            ok_d    = 1'b1;
            bad_d   = '0;
            rvld_d  = 1'b1;
            rdy_d   = 1'b1;
            state_d = PR_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            addr_d  = idx_q + 8'd1;
            state_d = PR_CH_REQ;
          end
        end
      end
      default: state_d = PR_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pt_reader.sv
// Directed bench for pt_reader with a 1-cycle-latency plaintext RAM model.
// Checks streamed bytes, completion timing, pass/fail and bad index.
module tb_pt_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       result_vld;
  logic       pt_ok;
  logic [7:0] bad_idx;

  logic [7:0] mem [256];
  logic [7:0] emitted [$];
  int         max_addr;
  int         n_checks = 0;
  int         n_errors = 0;

  int         stall_at = -1;
  int         stall_len = 0;
  int         stall_n = 0;
  logic [7:0] stall_ch = 8'h00;
  logic       stall_bad = 1'b0;
  logic       hold_low = 1'b0;

  pt_reader dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .out_char(out_char), .out_valid(out_valid),
    .out_ready(out_ready), .result_vld(result_vld),
    .pt_ok(pt_ok), .bad_idx(bad_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pt_rddata <= mem[pt_addr];

  always @(posedge clk)
    if (!rst && out_valid && out_ready) emitted.push_back(out_char);

  always @(negedge clk)
    if (int'(pt_addr) > max_addr) max_addr = int'(pt_addr);

  always @(negedge clk) begin
    if (hold_low) out_ready = 1'b0;
    else if (out_valid && emitted.size() == stall_at
             && stall_n < stall_len) begin
      out_ready = 1'b0;
      stall_n++;
      if (out_char != stall_ch) stall_bad = 1'b1;
    end else out_ready = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] b[$]);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < b.size(); i++) mem[i] = b[i];
  endtask

  task automatic run(input bit busy_en, output int cyc);
    emitted.delete();
    max_addr = 0;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk);
      cyc++;
      #1 en = busy_en && cyc >= 2 && cyc <= 8;
      @(negedge clk);
      if (rdy) break;
    end
    en = 1'b0;
    if (cyc >= 2000) check("timeout", 32'(cyc), 32'd0);
  endtask

  function automatic logic [31:0] stream_is(input logic [7:0] e[$]);
    if (emitted.size() != e.size()) return 0;
    foreach (e[i]) if (emitted[i] != e[i]) return 0;
    return 1;
  endfunction

  initial begin
    int cyc;
    logic [7:0] exp_q [$];
    load('{8'h00});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_addr", 32'(pt_addr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rvld", 32'(result_vld), 32'd0);
    check("rst_ok", 32'(pt_ok), 32'd0);
    check("rst_char", 32'(out_char), 32'd0);
    rst = 1'b0;

    // 1) HELLO
    load('{8'h05, "H", "E", "L", "L", "O"});
    run(0, cyc);
    check("hello_cyc", 32'(cyc), 32'd17);
    check("hello_str", stream_is('{"H", "E", "L", "L", "O"}), 32'd1);
    check("hello_ok", 32'(pt_ok), 32'd1);
    check("hello_bad", 32'(bad_idx), 32'd0);
    check("hello_rvld", 32'(result_vld), 32'd1);

    // 2) empty
    load('{8'h00});
    run(0, cyc);
    check("empty_cyc", 32'(cyc), 32'd2);
    check("empty_n", 32'(emitted.size()), 32'd0);
    check("empty_ok", 32'(pt_ok), 32'd1);
    check("empty_rvld", 32'(result_vld), 32'd1);

    // 3) abort on control byte
    load('{8'h04, "A", "B", 8'h07, "C"});
    run(0, cyc);
    check("abort_str", stream_is('{"A", "B"}), 32'd1);
    check("abort_ok", 32'(pt_ok), 32'd0);
    check("abort_bad", 32'(bad_idx), 32'd3);
    check("abort_maxa", 32'(max_addr), 32'd3);
    check("abort_cyc", 32'(cyc), 32'd10);

    // 4) stall 4 cycles on second byte
    load('{8'h05, "H", "E", "L", "L", "O"});
    stall_at = 1; stall_len = 4; stall_n = 0;
    stall_ch = "E"; stall_bad = 1'b0;
    run(0, cyc);
    stall_at = -1;
    check("stall_cyc", 32'(cyc), 32'd21);
    check("stall_n", 32'(stall_n), 32'd4);
    check("stall_hold", 32'(stall_bad), 32'd0);
    check("stall_str", stream_is('{"H", "E", "L", "L", "O"}), 32'd1);

    // 5) boundary bytes
    load('{8'h04, 8'h20, 8'h7E, 8'h1F, 8'h41});
    run(0, cyc);
    check("b1f_str", stream_is('{8'h20, 8'h7E}), 32'd1);
    check("b1f_ok", 32'(pt_ok), 32'd0);
    check("b1f_bad", 32'(bad_idx), 32'd3);
    load('{8'h02, 8'h7F, 8'h41});
    run(0, cyc);
    check("b7f_n", 32'(emitted.size()), 32'd0);
    check("b7f_bad", 32'(bad_idx), 32'd1);
    check("b7f_cyc", 32'(cyc), 32'd4);
    load('{8'h03, 8'h61, 8'h61, 8'hFF});
    run(0, cyc);
    check("bff_n", 32'(emitted.size()), 32'd2);
    check("bff_ok", 32'(pt_ok), 32'd0);
    check("bff_bad", 32'(bad_idx), 32'd3);
    load('{8'h01, 8'h80});
    run(0, cyc);
    check("b80_bad", 32'(bad_idx), 32'd1);

    // 6a) reset while a byte is pending
    load('{8'h05, "H", "E", "L", "L", "O"});
    hold_low = 1'b1;
    emitted.delete();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("emit_seen", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_rdy", 32'(rdy), 32'd1);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_rvld", 32'(result_vld), 32'd0);
    check("mrst_char", 32'(out_char), 32'd0);
    check("mrst_addr", 32'(pt_addr), 32'd0);
    rst = 1'b0;
    hold_low = 1'b0;
    @(negedge clk);

    // 6b) en pulses while busy are ignored
    run(1, cyc);
    check("busy_cyc", 32'(cyc), 32'd17);
    check("busy_str", stream_is('{"H", "E", "L", "L", "O"}), 32'd1);
    repeat (3) @(negedge clk);
    check("busy_idle", 32'(rdy), 32'd1);

    // 6c) L=255 of 'a'
    exp_q.delete();
    exp_q.push_back(8'hFF);
    for (int i = 1; i < 256; i++) exp_q.push_back("a");
    load(exp_q);
    exp_q.delete();
    for (int i = 1; i < 256; i++) exp_q.push_back("a");
    run(0, cyc);
    check("l255_cyc", 32'(cyc), 32'd767);
    check("l255_str", stream_is(exp_q), 32'd1);
    check("l255_ok", 32'(pt_ok), 32'd1);
    check("l255_maxa", 32'(max_addr), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
